// File: rtl/matmul_sequencer.sv
// matmul_sequencer: start/busy/done command sequencer for the systolic matmul array.
// Generates shift/line-switch timing for arbitrary dims and delayed bulk-write strobes.
module matmul_sequencer #(
    parameter int LANES  = 8,
    parameter int NUM_RF = 4,
    parameter int RF_W   = 2,
    parameter int PG_W   = 2,
    parameter int DIM_W  = 9,
    parameter int WB_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic                 start_i,
    input  logic [RF_W+PG_W-1:0] x_page_i,
    input  logic [RF_W+PG_W-1:0] w_page_i,
    input  logic [RF_W+PG_W-1:0] y_page_i,
    input  logic [2:0]           cfg_i,
    input  logic [DIM_W-1:0]     dim_k_i,
    input  logic [DIM_W-1:0]     dim_n_i,
    input  logic [DIM_W-1:0]     dim_m_i,
    input  logic [LANES-1:0]     clear_out_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 shift_en_o,
    output logic [NUM_RF-1:0]    rf_switch_o,
    output logic [NUM_RF-1:0]    rf_bulk_we_o,
    output logic [LANES-1:0]     y_valid_o,
    output logic [RF_W+PG_W-1:0] x_page_q_o,
    output logic [RF_W+PG_W-1:0] w_page_q_o,
    output logic [RF_W+PG_W-1:0] y_page_q_o,
    output logic [2:0]           cfg_q_o
);
    localparam int DR_W = $clog2(2*LANES+WB_LAT);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(2*LANES+WB_LAT-1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DIM_W-1:0]       wc_q, wc_d, wl_q, wl_d, xl_q, xl_d;
    logic [DIM_W-1:0]       dk_q, dk_d, dn_q, dn_d, dm_q, dm_d;
    logic [DR_W-1:0]        dc_q, dc_d;
    logic                   err_d;
    logic [RF_W+PG_W-1:0]   xp_d, wp_d, yp_d;
    logic [2:0]             cfg_d;
    logic [LANES-1:0]       yv_q [WB_LAT];
    logic                   w_sw, x_sw, conflict;
    logic [RF_W-1:0]        xr, wr, yr;

    assign xr = x_page_q_o[RF_W+PG_W-1:PG_W];
    assign wr = w_page_q_o[RF_W+PG_W-1:PG_W];
    assign yr = y_page_q_o[RF_W+PG_W-1:PG_W];
    assign w_sw = wc_q == dk_q;
    assign x_sw = w_sw && wl_q == dn_q;
    assign conflict = x_page_i[RF_W+PG_W-1:PG_W] == w_page_i[RF_W+PG_W-1:PG_W] ||
                      y_page_i[RF_W+PG_W-1:PG_W] == x_page_i[RF_W+PG_W-1:PG_W] ||
                      y_page_i[RF_W+PG_W-1:PG_W] == w_page_i[RF_W+PG_W-1:PG_W];
    assign busy_o = state_q == STREAM || state_q == DRAIN;
    assign done_o = state_q == DONE;
    assign shift_en_o = state_q == STREAM;
    assign y_valid_o = yv_q[WB_LAT-1];

    always_comb begin
        state_d = state_q;
        wc_d = wc_q;
        wl_d = wl_q;
        xl_d = xl_q;
        dk_d = dk_q;
        dn_d = dn_q;
        dm_d = dm_q;
        dc_d = dc_q;
        err_d = err_o;
        xp_d = x_page_q_o;
        wp_d = w_page_q_o;
        yp_d = y_page_q_o;
        cfg_d = cfg_q_o;
        case (state_q)
            IDLE: if (start_i) begin
                err_d = conflict;
                if (!conflict) begin
                    xp_d = x_page_i;
                    wp_d = w_page_i;
                    yp_d = y_page_i;
                    cfg_d = cfg_i;
                    dk_d = dim_k_i;
                    dn_d = dim_n_i;
                    dm_d = dim_m_i;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Wrapping on the final cell leaves every counter at 0 for the next command
                wc_d = w_sw ? '0 : wc_q + 1'b1;
                wl_d = w_sw ? (wl_q == dn_q ? '0 : wl_q + 1'b1) : wl_q;
                xl_d = x_sw ? (xl_q == dm_q ? '0 : xl_q + 1'b1) : xl_q;
                if (x_sw && xl_q == dm_q) begin
                    state_d = DRAIN;
                    dc_d = '0;
                end
            end
            DRAIN: begin
                dc_d = dc_q + 1'b1;
                state_d = dc_q == DR_LAST ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rf_switch_o = '0;
        if (shift_en_o) begin
            rf_switch_o[xr] = cfg_q_o[0] ? w_sw : x_sw;
            rf_switch_o[wr] = cfg_q_o[0] ? x_sw : w_sw;
        end
        rf_bulk_we_o = '0;
        rf_bulk_we_o[yr] = busy_o && |y_valid_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wc_q <= '0;
            wl_q <= '0;
            xl_q <= '0;
            dk_q <= '0;
            dn_q <= '0;
            dm_q <= '0;
            dc_q <= '0;
            err_o <= 1'b0;
            x_page_q_o <= '0;
            w_page_q_o <= '0;
            y_page_q_o <= '0;
            cfg_q_o <= '0;
            for (int i = 0; i < WB_LAT; i++) yv_q[i] <= '0;
        end else if (enable_i) begin
            state_q <= state_d;
            wc_q <= wc_d;
            wl_q <= wl_d;
            xl_q <= xl_d;
            dk_q <= dk_d;
            dn_q <= dn_d;
            dm_q <= dm_d;
            dc_q <= dc_d;
            err_o <= err_d;
            x_page_q_o <= xp_d;
            w_page_q_o <= wp_d;
            y_page_q_o <= yp_d;
            cfg_q_o <= cfg_d;
            yv_q[0] <= clear_out_i;
            for (int i = 1; i < WB_LAT; i++) yv_q[i] <= yv_q[i-1];
        end
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed self-checking bench for matmul_sequencer.
module tb_matmul_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       start = 1'b0;
    logic [3:0] xp = '0, wp = '0, yp = '0;
    logic [2:0] cfg = '0;
    logic [8:0] dk = '0, dn = '0, dm = '0;
    logic [7:0] co = '0;
    logic       busy, done, err, shift_en;
    logic [3:0] rf_switch, rf_bulk_we;
    logic [7:0] y_valid;
    logic [3:0] xq, wq, yq;
    logic [2:0] cfgq;
    int checks = 0;
    int failures = 0;

    matmul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .start_i(start),
        .x_page_i(xp), .w_page_i(wp), .y_page_i(yp), .cfg_i(cfg),
        .dim_k_i(dk), .dim_n_i(dn), .dim_m_i(dm), .clear_out_i(co),
        .busy_o(busy), .done_o(done), .err_o(err), .shift_en_o(shift_en),
        .rf_switch_o(rf_switch), .rf_bulk_we_o(rf_bulk_we), .y_valid_o(y_valid),
        .x_page_q_o(xq), .w_page_q_o(wq), .y_page_q_o(yq), .cfg_q_o(cfgq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] x, input logic [3:0] w, input logic [3:0] y,
                       input logic [2:0] c, input logic [8:0] k, input logic [8:0] n, input logic [8:0] m);
        xp = x; wp = w; yp = y; cfg = c; dk = k; dn = n; dm = m;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            seen = done;
            tick;
        end
        chk("done_within_bound", seen, 1'b1);
    endtask

    task automatic basic(input logic t);
        logic sw_w, sw_x;
        cmd(4'h0, 4'h4, 4'h8, {2'b00, t}, 9'd3, 9'd1, 9'd1);
        for (int c = 1; c <= 36; c++) begin
            sw_w = c % 4 == 0 && c <= 16;
            sw_x = c % 8 == 0 && c <= 16;
            chk($sformatf("shift_en t%0d c%0d", t, c), shift_en, c <= 16);
            chk($sformatf("rf_switch t%0d c%0d", t, c), rf_switch, t ? {2'b00, sw_x, sw_w} : {2'b00, sw_w, sw_x});
            chk($sformatf("busy t%0d c%0d", t, c), busy, c <= 33);
            chk($sformatf("done t%0d c%0d", t, c), done, c == 34);
            chk($sformatf("y_valid t%0d c%0d", t, c), y_valid, c == 21 ? 8'h81 : 8'h00);
            chk($sformatf("bulk_we t%0d c%0d", t, c), rf_bulk_we, c == 21 ? 4'b0100 : 4'b0000);
            co = c == 20 ? 8'h81 : 8'h00;
            tick;
        end
    endtask

    initial begin
        int n, sw, dn_cnt;
        start = 1'b1;
        cmd(4'h0, 4'h4, 4'h8, 3'b000, 9'd3, 9'd1, 9'd1);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_err", err, 1'b0);
            chk("rst_shift", shift_en, 1'b0);
            chk("rst_switch", rf_switch, 4'b0);
            chk("rst_yvalid", y_valid, 8'h00);
            tick;
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick;
        tick;
        chk("idle_after_release_busy", busy, 1'b0);
        chk("idle_after_release_shift", shift_en, 1'b0);

        basic(1'b0);
        basic(1'b1);
        chk("cfg_q_hold", cfgq, 3'b001);
        chk("x_page_q", xq, 4'h0);
        chk("w_page_q", wq, 4'h4);
        chk("y_page_q", yq, 4'h8);

        cmd(4'h1, 4'h2, 4'h8, 3'b000, 9'd0, 9'd0, 9'd0);
        chk("conflict_err", err, 1'b1);
        chk("conflict_busy", busy, 1'b0);
        chk("conflict_shift", shift_en, 1'b0);
        chk("conflict_pages_hold", xq, 4'h0);
        chk("conflict_cfg_hold", cfgq, 3'b001);
        tick;
        chk("conflict_busy_later", busy, 1'b0);

        cmd(4'h0, 4'h4, 4'h8, 3'b000, 9'd0, 9'd0, 9'd0);
        chk("dims0_err_cleared", err, 1'b0);
        chk("dims0_busy", busy, 1'b1);
        chk("dims0_shift", shift_en, 1'b1);
        chk("dims0_both_switch", rf_switch, 4'b0011);
        tick;
        chk("dims0_shift_one_cycle", shift_en, 1'b0);
        chk("dims0_drain_busy", busy, 1'b1);
        wait_done;

        cmd(4'h0, 4'h4, 4'h5, 3'b000, 9'd0, 9'd0, 9'd0);
        chk("ywconf_err", err, 1'b1);
        chk("ywconf_busy", busy, 1'b0);

        cmd(4'h0, 4'h4, 4'h8, 3'b000, 9'd3, 9'd1, 9'd1);
        n = 0;
        sw = 0;
        for (int c = 0; c < 60; c++) begin
            if (shift_en) n++;
            if (rf_switch[1]) sw++;
            if (c == 3) begin
                enable = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    tick;
                    chk("freeze_switch", rf_switch, 4'b0010);
                    chk("freeze_shift", shift_en, 1'b1);
                end
                enable = 1'b1;
            end
            tick;
        end
        chk("freeze_shift_total", n, 16);
        chk("freeze_wswitch_total", sw, 4);

        cmd(4'h0, 4'h4, 4'h8, 3'b000, 9'd3, 9'd1, 9'd1);
        for (int i = 0; i < 19; i++) tick;
        chk("drain_busy_pre_reset", busy, 1'b1);
        chk("drain_shift_pre_reset", shift_en, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_done", done, 1'b0);
        tick;
        rst_n = 1'b1;
        dn_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dn_cnt++;
            tick;
        end
        chk("no_done_after_reset", dn_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
